vga_pic_motion_ctrl: RTL and testbench
======================================

# vga_pic_motion_ctrl

Per-frame motion scheduler and ROM address generator for the VGA picture datapath. Once per frame it moves the top-left corner of an H_PIC x V_PIC ROM image inside the H_VALID x V_VALID active area, bouncing it off the edges. It also converts the live pixel coordinates from vga_ctrl into a ROM read address and hit flag. It sits between vga_ctrl and the picture ROM, and responds to run/stop/single-step commands.

## Interface
- H_VALID, 640, active pixels per line
- V_VALID, 480, active lines per frame
- H_PIC, 100, picture width in pixels
- V_PIC, 100, picture height in lines
- ADR_W, 14, ROM address width; H_PIC*V_PIC must be at most 2^ADR_W
- sys_clk  in  1  pixel clock; the single clock domain
- sys_rst  in  1  synchronous reset, active-high
- vsync  in  1  vga_ctrl vsync, active-high during the sync pulse
- pix_x  in  10  current active-area column from vga_ctrl
- pix_y  in  10  current active-area row from vga_ctrl
- cmd_start  in  1  one-cycle pulse: begin continuous motion
- cmd_stop  in  1  one-cycle pulse: halt motion
- cmd_step  in  1  one-cycle pulse: perform one update, then halt
- speed_x  in  3  pixels moved per frame in x; 0 freezes the axis
- speed_y  in  3  lines moved per frame in y; 0 freezes the axis
- pic_x  out  10  picture left column
- pic_y  out  10  picture top row
- running  out  1  high in S_RUN
- pic_hit  out  1  registered: the pixel lies inside the picture
- rom_addr  out  ADR_W  registered ROM read address

## Operation
- Limits: X_LIM = H_VALID-H_PIC and Y_LIM = V_VALID-V_PIC. Invariants: 0 ≤ pic_x ≤ X_LIM and 0 ≤ pic_y ≤ Y_LIM.
- Frame tick: a one-cycle internal pulse on the cycle after a vsync 0→1 edge, detected with a registered copy of vsync. pic_x/pic_y change only on the tick, so there is no tearing in the active area.
- FSM states:
  - S_IDLE (reset state): cmd_start → S_RUN; cmd_step → S_STEP.
  - S_RUN: every tick updates the position; cmd_stop → S_IDLE.
  - S_STEP: the next tick updates the position once, then → S_IDLE. cmd_stop → S_IDLE with no update.
- Command priority when pulses coincide: stop > start > step. In S_RUN, cmd_start and cmd_step are ignored.
- speed_x/speed_y are sampled only on the tick.
- Axis update, x shown (y is identical with Y_LIM/dir_y). All arithmetic is 11-bit unsigned, so nothing overflows.
  - dir_x=1 (right): if pic_x+speed_x ≥ X_LIM, then pic_x←X_LIM and dir_x←0; else pic_x←pic_x+speed_x.
  - dir_x=0 (left): if pic_x ≤ speed_x, then pic_x←0 and dir_x←1; else pic_x←pic_x−speed_x.
  - A speed of 0 leaves both position and direction unchanged.
- Address path, every cycle:
  - pic_hit ← (pic_x ≤ pix_x < pic_x+H_PIC) and (pic_y ≤ pix_y < pic_y+V_PIC).
  - rom_addr ← (pix_y−pic_y)*H_PIC + (pix_x−pic_x) when hit, else 0.

## Timing
- Reset values: pic_x=0, pic_y=0, dir_x=1, dir_y=1, state S_IDLE, running=0, pic_hit=0, rom_addr=0, vsync delay register=0.
- Reset mid-operation: all of the above apply on the first edge with sys_rst=1. A pending step is discarded.
- Position latency: pic_x/pic_y update 2 cycles after the vsync rising edge (1 for edge detect, 1 for the register).
- A command pulse takes effect on the next clock edge. The tick that is effective in the same cycle uses the pre-command state.
- Address latency: 1 cycle from pix_x/pix_y to pic_hit/rom_addr. The ROM adds 1 more, so the downstream rgb mux must delay pic_hit by one cycle to align with ROM data.
- running is registered and equals (state==S_RUN).

## Configuration
- VGA_PIC_MOTION_WRAP_EN, when defined: edges wrap instead of bounce, and dir_x/dir_y stay at 1.
  - Update rule: if pic_x+speed_x > X_LIM, then pic_x ← pic_x+speed_x−(X_LIM+1); else add. y is identical with Y_LIM.
- Undefined: bounce behaviour as specified in Operation.

## Test plan
Benches use H_VALID=60, V_VALID=50, H_PIC=10, V_PIC=10 (X_LIM=50, Y_LIM=40), unless a line says otherwise.
- X bounce: reset, cmd_start, speed_x=3 → after tick 1 pic_x=3; after tick 17 pic_x=50 and dir_x=0; after tick 18 pic_x=47.
- Y bounce: speed_y=2 → pic_y=40 after tick 20 and 38 after tick 21. speed_y=0 keeps pic_y constant across 5 ticks.
- Commands:
  - cmd_start and cmd_stop in the same cycle → state stays S_IDLE and running=0.
  - cmd_step in S_IDLE → exactly one position update at the next tick, then S_IDLE; pic_x is unchanged over the following 3 ticks.
- Address: pic_x=3, pic_y=2; drive pix_x=5, pix_y=4 → next cycle pic_hit=1, rom_addr=22. Drive pix_x=13 → pic_hit=0, rom_addr=0. Also check the corner pix_x=12, pix_y=11 → rom_addr=99.
- Reset mid-run: assert sys_rst for 1 cycle at pic_x=20 → next edge pic_x=0, pic_y=0, running=0, rom_addr=0. The next tick produces no movement.
- Wrap (VGA_PIC_MOTION_WRAP_EN defined): speed_x=3 from pic_x=48 → next tick pic_x=0, then pic_x=3.

Source files
------------

// File: rtl/vga_pic_motion_ctrl.sv
// Per-frame picture motion scheduler (run/stop/step FSM, bounce or wrap edges) and
// ROM address generator. Define VGA_PIC_MOTION_WRAP_EN to wrap at the edges instead of bouncing.
module vga_pic_motion_ctrl #(
    parameter int H_VALID = 640,
    parameter int V_VALID = 480,
    parameter int H_PIC   = 100,
    parameter int V_PIC   = 100,
    parameter int ADR_W   = 14
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             vsync,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_step,
    input  logic [2:0]       speed_x,
    input  logic [2:0]       speed_y,
    output logic [9:0]       pic_x,
    output logic [9:0]       pic_y,
    output logic             running,
    output logic             pic_hit,
    output logic [ADR_W-1:0] rom_addr,
    output logic [1:0]       state_dbg
);

    localparam logic [10:0]      X_LIM   = 11'(H_VALID - H_PIC);
    localparam logic [10:0]      Y_LIM   = 11'(V_VALID - V_PIC);
    localparam logic [10:0]      H_PIC_W = 11'(H_PIC);
    localparam logic [10:0]      V_PIC_W = 11'(V_PIC);
    localparam logic [ADR_W-1:0] H_PIC_A = ADR_W'(H_PIC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               vsync_q, vsync_d;
    logic               tick_q, tick_d;
    logic [9:0]         pic_x_q, pic_x_d, pic_y_q, pic_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic               running_q, running_d;
    logic               pic_hit_q, pic_hit_d;
    logic [ADR_W-1:0]   rom_addr_q, rom_addr_d;

    // Returns {dir, pos} after one frame of motion on one axis.
    function automatic logic [10:0] axis_next(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [2:0]  spd,
                                              input logic [10:0] lim);
        logic [10:0] p11, s11, sum, diff, wsum;
        p11  = {1'b0, pos};
        s11  = {8'd0, spd};
        sum  = p11 + s11;
        diff = p11 - s11;
        wsum = sum - (lim + 11'd1);
        axis_next = {dir, pos};
`ifdef VGA_PIC_MOTION_WRAP_EN
        if (spd != 3'd0) begin
            if (sum > lim) axis_next = {dir, wsum[9:0]};
            else           axis_next = {dir, sum[9:0]};
        end
`else
        if (spd != 3'd0) begin
            if (dir) begin
                if (sum >= lim) axis_next = {1'b0, lim[9:0]};
                else            axis_next = {1'b1, sum[9:0]};
            end else begin
                if (p11 <= s11) axis_next = {1'b1, 10'd0};
                else            axis_next = {1'b0, diff[9:0]};
            end
        end
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_stop)       state_d = S_IDLE;
                else if (cmd_start) state_d = S_RUN;
                else if (cmd_step)  state_d = S_STEP;
            end
            S_RUN: begin
                if (cmd_stop) state_d = S_IDLE;
            end
            S_STEP: begin
                if (cmd_stop)       state_d = S_IDLE;
                else if (cmd_start) state_d = S_RUN;
                else if (tick_q)    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN);
    end

    // Motion uses the state held before any command arriving in the same cycle.
    always_comb begin
        logic [10:0] nx, ny;
        vsync_d = vsync;
        tick_d  = vsync & ~vsync_q;
        pic_x_d = pic_x_q;
        pic_y_d = pic_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        nx = axis_next(pic_x_q, dir_x_q, speed_x, X_LIM);
        ny = axis_next(pic_y_q, dir_y_q, speed_y, Y_LIM);
        if (tick_q && (state_q == S_RUN || state_q == S_STEP)) begin
            dir_x_d = nx[10];
            pic_x_d = nx[9:0];
            dir_y_d = ny[10];
            pic_y_d = ny[9:0];
        end
    end

    always_comb begin
        logic [10:0] px, py, x_end, y_end;
        logic [9:0]  dx, dy;
        px    = {1'b0, pix_x};
        py    = {1'b0, pix_y};
        x_end = {1'b0, pic_x_q} + H_PIC_W;
        y_end = {1'b0, pic_y_q} + V_PIC_W;
        dx    = pix_x - pic_x_q;
        dy    = pix_y - pic_y_q;
        pic_hit_d = (pix_x >= pic_x_q) && (px < x_end) &&
                    (pix_y >= pic_y_q) && (py < y_end);
        rom_addr_d = '0;
        if (pic_hit_d) rom_addr_d = ADR_W'(dy) * H_PIC_A + ADR_W'(dx);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b0;
            tick_q     <= 1'b0;
            pic_x_q    <= 10'd0;
            pic_y_q    <= 10'd0;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            running_q  <= 1'b0;
            pic_hit_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_d;
            tick_q     <= tick_d;
            pic_x_q    <= pic_x_d;
            pic_y_q    <= pic_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            running_q  <= running_d;
            pic_hit_q  <= pic_hit_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign pic_x     = pic_x_q;
    assign pic_y     = pic_y_q;
    assign running   = running_q;
    assign pic_hit   = pic_hit_q;
    assign rom_addr  = rom_addr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vga_pic_motion_ctrl.sv
// Directed bench for vga_pic_motion_ctrl on a 60x50 screen with a 10x10 picture
// (X_LIM=50, Y_LIM=40); expected values are hand-computed.
module tb_vga_pic_motion_ctrl;

    localparam int ADR_W = 7;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             vsync = 1'b0;
    logic [9:0]       pix_x = '0, pix_y = '0;
    logic             cmd_start = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0;
    logic [2:0]       speed_x = '0, speed_y = '0;
    logic [9:0]       pic_x, pic_y;
    logic             running, pic_hit;
    logic [ADR_W-1:0] rom_addr;
    logic [1:0]       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    vga_pic_motion_ctrl #(
        .H_VALID(60), .V_VALID(50), .H_PIC(10), .V_PIC(10), .ADR_W(ADR_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .vsync(vsync),
        .pix_x(pix_x), .pix_y(pix_y),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
        .speed_x(speed_x), .speed_y(speed_y),
        .pic_x(pic_x), .pic_y(pic_y), .running(running),
        .pic_hit(pic_hit), .rom_addr(rom_addr), .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks: all inputs change on the falling edge.
    task automatic do_reset();
        @(negedge sys_clk) sys_rst = 1'b1;
        @(negedge sys_clk) sys_rst = 1'b0;
    endtask

    task automatic send_cmd(input logic st, input logic sp, input logic stp);
        @(negedge sys_clk);
        cmd_start = st; cmd_stop = sp; cmd_step = stp;
        @(negedge sys_clk);
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    endtask

    // One frame: vsync high for two cycles, low for two; the position settles before return.
    task automatic do_tick();
        @(negedge sys_clk) vsync = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk) vsync = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic set_pix(input int x, input int y);
        @(negedge sys_clk);
        pix_x = 10'(x); pix_y = 10'(y);
        @(negedge sys_clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_pic_x", pic_x, 0);
        check_eq("rst_pic_y", pic_y, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_state", state_dbg, 0);
        check_eq("rst_hit", pic_hit, 1);   // pix (0,0) lies inside the picture at (0,0)
        check_eq("rst_addr", rom_addr, 0);

`ifndef VGA_PIC_MOTION_WRAP_EN
        // Bounce on both axes, with a latency check on the first tick
        speed_x = 3'd3; speed_y = 3'd2;
        send_cmd(1'b1, 1'b0, 1'b0);
        check_eq("run_running", running, 1);
        check_eq("run_state", state_dbg, 1);
        @(negedge sys_clk) vsync = 1'b1;
        @(posedge sys_clk); #1;
        check_eq("lat_e1_pic_x", pic_x, 0);
        @(posedge sys_clk); #1;
        check_eq("lat_e2_pic_x", pic_x, 3);
        @(negedge sys_clk) vsync = 1'b0;
        @(negedge sys_clk);
        check_eq("t1_pic_y", pic_y, 2);
        for (int t = 2; t <= 21; t++) begin
            do_tick();
            if (t == 16) check_eq("t16_pic_x", pic_x, 48);
            if (t == 17) check_eq("t17_pic_x", pic_x, 50);
            if (t == 18) check_eq("t18_pic_x", pic_x, 47);
            if (t == 19) check_eq("t19_pic_y", pic_y, 38);
            if (t == 20) check_eq("t20_pic_y", pic_y, 40);
            if (t == 21) check_eq("t21_pic_y", pic_y, 38);
        end
        check_eq("t21_pic_x", pic_x, 38);

        // speed_y=0 freezes y; x keeps moving left
        speed_y = 3'd0;
        for (int t = 0; t < 5; t++) begin
            do_tick();
            check_eq("y_frozen", pic_y, 38);
        end
        check_eq("x_after_freeze", pic_x, 23);

        // Stop, then start+stop together stays idle
        send_cmd(1'b0, 1'b1, 1'b0);
        check_eq("stop_running", running, 0);
        send_cmd(1'b1, 1'b1, 1'b0);
        check_eq("startstop_running", running, 0);
        check_eq("startstop_state", state_dbg, 0);
        do_tick();
        check_eq("idle_no_move", pic_x, 23);

        // Single step: one update, then idle
        send_cmd(1'b0, 1'b0, 1'b1);
        check_eq("step_state", state_dbg, 2);
        check_eq("step_running", running, 0);
        do_tick();
        check_eq("step_pic_x", pic_x, 20);
        check_eq("step_back_idle", state_dbg, 0);
        for (int t = 0; t < 3; t++) begin
            do_tick();
            check_eq("post_step_pic_x", pic_x, 20);
        end

        // Reset mid-run at pic_x=20, pic_y=38, with the pixel inside the picture
        send_cmd(1'b1, 1'b0, 1'b0);
        set_pix(25, 40);
        check_eq("pre_rst_addr", rom_addr, 25);
        @(negedge sys_clk) sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        check_eq("mid_rst_pic_x", pic_x, 0);
        check_eq("mid_rst_pic_y", pic_y, 0);
        check_eq("mid_rst_running", running, 0);
        check_eq("mid_rst_addr", rom_addr, 0);
        @(negedge sys_clk) sys_rst = 1'b0;
        do_tick();
        check_eq("post_rst_pic_x", pic_x, 0);
        check_eq("post_rst_pic_y", pic_y, 0);

        // Address path with the picture at (3,2)
        speed_x = 3'd3; speed_y = 3'd2;
        send_cmd(1'b0, 1'b0, 1'b1);
        do_tick();
        check_eq("addr_pic_x", pic_x, 3);
        check_eq("addr_pic_y", pic_y, 2);
        set_pix(5, 4);
        check_eq("hit_5_4", pic_hit, 1);
        check_eq("addr_5_4", rom_addr, 22);
        set_pix(13, 4);
        check_eq("hit_13_4", pic_hit, 0);
        check_eq("addr_13_4", rom_addr, 0);
        set_pix(12, 11);
        check_eq("hit_12_11", pic_hit, 1);
        check_eq("addr_12_11", rom_addr, 99);
        set_pix(3, 2);
        check_eq("hit_3_2", pic_hit, 1);
        check_eq("addr_3_2", rom_addr, 0);
        set_pix(2, 5);
        check_eq("hit_2_5", pic_hit, 0);
        set_pix(5, 12);
        check_eq("hit_5_12", pic_hit, 0);
`else
        // Wrap: 16 ticks at speed 3 reach 48, then 51 wraps to 0, then 3
        speed_x = 3'd3;
        send_cmd(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 18; t++) begin
            do_tick();
            if (t == 16) check_eq("wrap_t16_pic_x", pic_x, 48);
            if (t == 17) check_eq("wrap_t17_pic_x", pic_x, 0);
            if (t == 18) check_eq("wrap_t18_pic_x", pic_x, 3);
        end
        check_eq("wrap_pic_y", pic_y, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
